// File: rtl/control_pc_salto_if.sv
// Fetch-side PC / branch redirect bundle.
// master drives stall/branch inputs, slave returns pc, flush, status.
interface control_pc_salto_if #(
  parameter int CNT_W = 16
);
  logic             stall_if;
  logic             stall_id;
  logic             es_branch;
  logic             salto;
  logic [31:0]      destino;
  logic [31:0]      pc;
  logic [31:0]      pc_mas4;
  logic             flush_ifid;
  logic             pendiente;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_taken;

  modport master (
    output stall_if, stall_id, es_branch, salto, destino,
    input  pc, pc_mas4, flush_ifid, pendiente,
    input  cnt_branch, cnt_taken
  );

  modport slave (
    input  stall_if, stall_id, es_branch, salto, destino,
    output pc, pc_mas4, flush_ifid, pendiente,
    output cnt_branch, cnt_taken
  );
endinterface

// File: rtl/control_pc_salto.sv
// PC register with ID-stage branch redirect, IF/ID flush, deferred
// redirect under fetch stall, and saturating branch counters.
// Ports: clk, reset (sync, active high), bus (control_pc_salto_if.slave).
module control_pc_salto #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  control_pc_salto_if.slave   bus
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } st_t;

  st_t              state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_t_q;
  logic             flush;

  logic        ev_br;
  logic        ev_taken;
  logic [31:0] tgt;

  // A branch whose operands are not ready has no decision yet.
  assign ev_br    = bus.es_branch & ~bus.stall_id;
  assign ev_taken = ev_br & bus.salto;
  assign tgt      = {bus.destino[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ev_taken) begin
          flush = 1'b1;
          if (bus.stall_if) begin
            pend_d  = tgt;
            state_d = PEND;
          end else begin
            pc_d = tgt;
          end
        end else if (!bus.stall_if) begin
          pc_d = pc_q + 32'd4;
        end
      end
      PEND: begin
        // Keep killing whatever sits in IF/ID until the
        // redirect is finally applied.
        flush = 1'b1;
        if (!bus.stall_if) begin
          pc_d    = pend_q;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
      cnt_b_q <= '0;
      cnt_t_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      if (state_q == RUN) begin
        if (ev_br && cnt_b_q != '1)
          cnt_b_q <= cnt_b_q + 1'b1;
        if (ev_taken && cnt_t_q != '1)
          cnt_t_q <= cnt_t_q + 1'b1;
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_mas4    = pc_q + 32'd4;
  assign bus.flush_ifid = flush & ~reset;
  assign bus.pendiente  = (state_q == PEND) & ~reset;
  assign bus.cnt_branch = cnt_b_q;
  assign bus.cnt_taken  = cnt_t_q;

endmodule

// File: doc/control_pc_salto.md
Name: control_pc_salto

Overview:
- Fetch-side consumer of the ID-stage branch decision (salto) in the 5-stage MIPS pipeline.
- Owns the PC register and sequences PC+4 / branch-target redirects.
- Generates the IF/ID flush for the wrong-path instruction.
- Defers a redirect that arrives while fetch is stalled, and keeps saturating branch statistics counters.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
CNT_W, 16, width of each statistics counter

Ports:
clk  input  1  single system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall_if  input  1  freeze PC (instruction memory not ready / hazard unit)
stall_id  input  1  branch operands in ID not yet valid; salto must be ignored
es_branch  input  1  instruction in ID is BEQ/BNE (opcode 000100/000101 decoded upstream)
salto  input  1  branch-taken result from the ID-stage comparator
destino  input  32  branch target computed in ID
pc  output  32  current fetch address to instruction memory
pc_mas4  output  32  pc + 4, forwarded to IF/ID
flush_ifid  output  1  clear IF/ID register this cycle (combinational)
pendiente  output  1  a deferred redirect is held (state PEND)
cnt_branch  output  CNT_W  branches resolved since reset
cnt_taken  output  CNT_W  taken branches since reset

Behaviour:
- Definitions:
  - ev_br = es_branch & ~stall_id
  - ev_taken = ev_br & salto
  - tgt = {destino[31:2], 2'b00}: target is always word-aligned, low bits forced to zero.
- Reset (sync, reset high at a clock edge):
  - pc = RESET_PC, state = RUN.
  - Pending-target register = 0; cnt_branch = cnt_taken = 0.
  - flush_ifid = 0 and pendiente = 0 while reset is high.
  - Reset dominates every other input, including a pending redirect.
- pc_mas4 = pc + 4, combinational, modulo 2^32 (32'hFFFFFFFC + 4 = 0).
- State RUN:
  - ev_taken & ~stall_if: next pc = tgt; flush_ifid = 1 in the same cycle; stay RUN.
  - ev_taken & stall_if: pend_pc <= tgt; next state PEND; pc held; flush_ifid = 1 in the same cycle, which kills the wrong-path instruction.
  - otherwise, ~stall_if: pc <= pc + 4.
  - otherwise, stall_if: pc held.
  - Without ev_taken, flush_ifid = 0.
- State PEND:
  - pendiente = 1.
  - New ev_br / ev_taken are ignored for both redirect and counters; ID holds only bubbles here.
  - stall_if = 1: hold pc and pend_pc; flush_ifid = 1 every cycle.
  - stall_if = 0: pc <= pend_pc; flush_ifid = 1; next state RUN.
- Latency: one edge from a taken decision to pc = tgt (RUN, no stall). The instruction fetched at the branch-decision cycle is flushed; there is no delay slot.
- Predict-not-taken is implicit. A not-taken branch costs zero cycles and produces no flush.
- Counters:
  - cnt_branch +1 on ev_br in RUN; cnt_taken +1 on ev_taken in RUN.
  - Both saturate at all-ones and never wrap.
  - A branch held by stall_id is counted exactly once, at the cycle stall_id drops.
- es_branch & stall_id & salto = X is legal: salto is don't-care, with no effect on pc, flush or counters.

Test Plan:
- Reset, then 4 cycles with no stalls and no branches -> pc = 0, 4, 8, 12; flush_ifid = 0; counters 0.
- At pc = 0x10: es_branch=1, salto=1, destino=0x43 -> flush_ifid = 1 that cycle; next pc = 0x40; cnt_branch = 1, cnt_taken = 1.
- es_branch=1, salto=0 at pc = 0x20 -> next pc = 0x24; flush_ifid = 0; cnt_branch +1, cnt_taken unchanged.
- Taken branch to 0x80 with stall_if=1 for 3 cycles -> pendiente = 1 and pc frozen for those 3 cycles; flush_ifid high throughout. A second taken branch during PEND is ignored and not counted. Edge after stall_if drops: pc = 0x80, pendiente = 0.
- es_branch=1, stall_id=1, salto toggling for 2 cycles, then stall_id=0 with salto=1, destino=0x100 -> no redirect and no count while stalled. Then exactly one redirect to 0x100; cnt_branch +1, cnt_taken +1.
- CNT_W=2, 5 taken branches -> cnt_taken = 3 and held. Assert reset mid-PEND -> pc = RESET_PC, pendiente = 0, counters 0 on the next edge.
